// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: default widths, the per-entry record and the tag type.
package rob_pkg;

    localparam int PREG_W = 6;
    localparam int TAG_W  = 6;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispredict;
        logic              rd_alloc;
        logic              is_branch;
        logic [PREG_W-1:0] rd_old_p;
        logic [PREG_W-1:0] rd_new_p;
    } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire with mispredict recovery.
// Define ROB_PERF_EN to add the commit/flush performance counters.
module rob #(
    parameter int N_ENTRIES = 64,
    parameter int N_PHYS    = 64,
    parameter int TAG_W     = $clog2(N_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_valid_i,
    output logic                      alloc_ready_o,
    input  logic                      alloc_rd_alloc_i,
    input  logic [$clog2(N_PHYS)-1:0] alloc_rd_old_p_i,
    input  logic [$clog2(N_PHYS)-1:0] alloc_rd_new_p_i,
    input  logic                      alloc_is_branch_i,
    output logic [TAG_W-1:0]          alloc_tag_o,
    input  logic                      cmpl_valid_i,
    input  logic [TAG_W-1:0]          cmpl_tag_i,
    input  logic                      cmpl_mispredict_i,
    output logic                      commit_free_valid_o,
    output logic [$clog2(N_PHYS)-1:0] commit_free_preg_o,
    output logic                      recover_o,
    output logic [TAG_W-1:0]          head_tag_o,
`ifdef ROB_PERF_EN
    output logic [31:0]               perf_commit_cnt_o,
    output logic [31:0]               perf_flush_cnt_o,
`endif
    output logic                      empty_o
);

    import rob_pkg::*;

    localparam int              PW   = $clog2(N_PHYS);
    localparam logic [TAG_W:0]  FULL = (TAG_W+1)'(N_ENTRIES);

    rob_entry_t [N_ENTRIES-1:0] entries_q;
    logic [TAG_W-1:0]           head_q, head_d;
    logic [TAG_W-1:0]           tail_q, tail_d;
    logic [TAG_W:0]             count_q, count_d;
    logic                       commit;
    logic                       do_alloc;
    rob_entry_t                 head_entry;

    assign head_entry          = entries_q[head_q];
    assign commit              = head_entry.valid && head_entry.done;
    assign recover_o           = commit && head_entry.mispredict;
    assign commit_free_valid_o = commit && head_entry.rd_alloc;
    assign commit_free_preg_o  = commit_free_valid_o ? PW'(head_entry.rd_old_p) : '0;
    assign alloc_ready_o       = (count_q != FULL) && !recover_o;
    assign do_alloc            = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o         = tail_q;
    assign head_tag_o          = head_q;
    assign empty_o             = (count_q == '0);

    // A retiring mispredict collapses the window to just past the branch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (recover_o) begin
            head_d  = head_q + TAG_W'(1);
            tail_d  = head_q + TAG_W'(1);
            count_d = '0;
        end else begin
            if (commit)   head_d = head_q + TAG_W'(1);
            if (do_alloc) tail_d = tail_q + TAG_W'(1);
            if (do_alloc && !commit)      count_d = count_q + (TAG_W+1)'(1);
            else if (!do_alloc && commit) count_d = count_q - (TAG_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (recover_o) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    entries_q[i].valid <= 1'b0;
                end
            end else begin
                if (cmpl_valid_i && entries_q[cmpl_tag_i].valid) begin
                    entries_q[cmpl_tag_i].done       <= 1'b1;
                    entries_q[cmpl_tag_i].mispredict <= cmpl_mispredict_i
                                                        && entries_q[cmpl_tag_i].is_branch;
                end
                if (commit) begin
                    entries_q[head_q].valid <= 1'b0;
                end
                // Full blocks allocation, so tail never aliases the retiring head here.
                if (do_alloc) begin
                    entries_q[tail_q].valid      <= 1'b1;
                    entries_q[tail_q].done       <= 1'b0;
                    entries_q[tail_q].mispredict <= 1'b0;
                    entries_q[tail_q].rd_alloc   <= alloc_rd_alloc_i;
                    entries_q[tail_q].is_branch  <= alloc_is_branch_i;
                    entries_q[tail_q].rd_old_p   <= PREG_W'(alloc_rd_old_p_i);
                    entries_q[tail_q].rd_new_p   <= PREG_W'(alloc_rd_new_p_i);
                end
            end
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] perf_commit_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commit_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (commit)    perf_commit_q <= perf_commit_q + 32'd1;
            if (recover_o) perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign perf_commit_cnt_o = perf_commit_q;
    assign perf_flush_cnt_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_rob.sv
// Directed testbench for rob: in-order retire, full/wrap, x0 dest, mispredict recovery, invalid
// completions and asynchronous reset, each with hand-computed expected values.
module tb_rob;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid_i;
    logic       alloc_ready_o;
    logic       alloc_rd_alloc_i;
    logic [5:0] alloc_rd_old_p_i;
    logic [5:0] alloc_rd_new_p_i;
    logic       alloc_is_branch_i;
    logic [5:0] alloc_tag_o;
    logic       cmpl_valid_i;
    logic [5:0] cmpl_tag_i;
    logic       cmpl_mispredict_i;
    logic       commit_free_valid_o;
    logic [5:0] commit_free_preg_o;
    logic       recover_o;
    logic [5:0] head_tag_o;
    logic       empty_o;
`ifdef ROB_PERF_EN
    logic [31:0] perf_commit_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    rob dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_rd_alloc_i    (alloc_rd_alloc_i),
        .alloc_rd_old_p_i    (alloc_rd_old_p_i),
        .alloc_rd_new_p_i    (alloc_rd_new_p_i),
        .alloc_is_branch_i   (alloc_is_branch_i),
        .alloc_tag_o         (alloc_tag_o),
        .cmpl_valid_i        (cmpl_valid_i),
        .cmpl_tag_i          (cmpl_tag_i),
        .cmpl_mispredict_i   (cmpl_mispredict_i),
        .commit_free_valid_o (commit_free_valid_o),
        .commit_free_preg_o  (commit_free_preg_o),
        .recover_o           (recover_o),
        .head_tag_o          (head_tag_o),
`ifdef ROB_PERF_EN
        .perf_commit_cnt_o   (perf_commit_cnt_o),
        .perf_flush_cnt_o    (perf_flush_cnt_o),
`endif
        .empty_o             (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1ns past the edge so outputs are stable when read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid_i     = 1'b0;
        alloc_rd_alloc_i  = 1'b0;
        alloc_rd_old_p_i  = '0;
        alloc_rd_new_p_i  = '0;
        alloc_is_branch_i = 1'b0;
        cmpl_valid_i      = 1'b0;
        cmpl_tag_i        = '0;
        cmpl_mispredict_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic rd, input logic [5:0] oldp, input logic [5:0] newp,
                                 input logic br);
        alloc_valid_i     = 1'b1;
        alloc_rd_alloc_i  = rd;
        alloc_rd_old_p_i  = oldp;
        alloc_rd_new_p_i  = newp;
        alloc_is_branch_i = br;
    endtask

    task automatic complete(input logic [5:0] tag, input logic mp);
        cmpl_valid_i      = 1'b1;
        cmpl_tag_i        = tag;
        cmpl_mispredict_i = mp;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        testsRun++; if (alloc_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready got %b want 1", alloc_ready_o); end
        testsRun++; if (alloc_tag_o !== 6'd0) begin testsFailed++; $display("[TB] FAIL reset_tag got %0d want 0", alloc_tag_o); end
        testsRun++; if ({commit_free_valid_o, recover_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_free_rec got %b want 00", {commit_free_valid_o, recover_o}); end
        testsRun++; if (commit_free_preg_o !== 6'd0) begin testsFailed++; $display("[TB] FAIL reset_preg got %0d want 0", commit_free_preg_o); end
        testsRun++; if ({empty_o, head_tag_o} !== {1'b1, 6'd0}) begin testsFailed++; $display("[TB] FAIL reset_empty_head got %b/%0d want 1/0", empty_o, head_tag_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'(5 + i), 6'(20 + i), 1'b0);
            testsRun++; if (alloc_tag_o !== 6'(i)) begin testsFailed++; $display("[TB] FAIL io_tag%0d got %0d want %0d", i, alloc_tag_o, i); end
            tick();
        end
        idle();
        complete(6'd2, 1'b0);
        tick();
        idle();
        testsRun++; if (commit_free_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL io_no_early got %b want 0", commit_free_valid_o); end
        complete(6'd0, 1'b0);
        tick();
        complete(6'd1, 1'b0);
        #1;
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b1, 6'd5}) begin testsFailed++; $display("[TB] FAIL io_free0 got %b/%0d want 1/5", commit_free_valid_o, commit_free_preg_o); end
        tick();
        idle();
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b1, 6'd6}) begin testsFailed++; $display("[TB] FAIL io_free1 got %b/%0d want 1/6", commit_free_valid_o, commit_free_preg_o); end
        tick();
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b1, 6'd7}) begin testsFailed++; $display("[TB] FAIL io_free2 got %b/%0d want 1/7", commit_free_valid_o, commit_free_preg_o); end
        tick();
        testsRun++; if ({empty_o, head_tag_o, commit_free_valid_o} !== {1'b1, 6'd3, 1'b0}) begin testsFailed++; $display("[TB] FAIL io_empty got %b/%0d/%b want 1/3/0", empty_o, head_tag_o, commit_free_valid_o); end
    endtask

    task automatic test_x0_dest();
        applyStimulus(1'b0, 6'd9, 6'd30, 1'b0);
        tick();
        idle();
        complete(6'd3, 1'b0);
        tick();
        idle();
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b0, 6'd0}) begin testsFailed++; $display("[TB] FAIL x0_free got %b/%0d want 0/0", commit_free_valid_o, commit_free_preg_o); end
        tick();
        testsRun++; if ({empty_o, head_tag_o} !== {1'b1, 6'd4}) begin testsFailed++; $display("[TB] FAIL x0_head got %b/%0d want 1/4", empty_o, head_tag_o); end
    endtask

    task automatic test_mispredict();
        applyStimulus(1'b1, 6'd11, 6'd40, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'(12 + i), 6'(41 + i), 1'b0);
            tick();
        end
        idle();
        complete(6'd4, 1'b1);
        tick();
        applyStimulus(1'b1, 6'd50, 6'd51, 1'b0);
        complete(6'd5, 1'b0);
        #1;
        testsRun++; if (recover_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mp_pulse got %b want 1", recover_o); end
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b1, 6'd11}) begin testsFailed++; $display("[TB] FAIL mp_free got %b/%0d want 1/11", commit_free_valid_o, commit_free_preg_o); end
        testsRun++; if (alloc_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mp_block got %b want 0", alloc_ready_o); end
        tick();
        idle();
        #1;
        testsRun++; if ({recover_o, commit_free_valid_o} !== 2'b00) begin testsFailed++; $display("[TB] FAIL mp_one_cycle got %b want 00", {recover_o, commit_free_valid_o}); end
        testsRun++; if ({empty_o, head_tag_o, alloc_tag_o} !== {1'b1, 6'd5, 6'd5}) begin testsFailed++; $display("[TB] FAIL mp_ptrs got %b/%0d/%0d want 1/5/5", empty_o, head_tag_o, alloc_tag_o); end
    endtask

    task automatic test_invalid_cmpl();
        complete(6'd10, 1'b0);
        tick();
        idle();
        testsRun++; if ({empty_o, head_tag_o, alloc_tag_o, commit_free_valid_o} !== {1'b1, 6'd5, 6'd5, 1'b0}) begin testsFailed++; $display("[TB] FAIL inv_nochange got %b/%0d/%0d/%b want 1/5/5/0", empty_o, head_tag_o, alloc_tag_o, commit_free_valid_o); end
        applyStimulus(1'b1, 6'd33, 6'd34, 1'b0);
        tick();
        idle();
        complete(6'd5, 1'b0);
        #1;
        testsRun++; if (commit_free_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL same_cycle got %b want 0", commit_free_valid_o); end
        tick();
        idle();
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o} !== {1'b1, 6'd33}) begin testsFailed++; $display("[TB] FAIL deferred got %b/%0d want 1/33", commit_free_valid_o, commit_free_preg_o); end
        tick();
    endtask

    task automatic test_full_wrap();
        int wrapSeen;
        wrapSeen = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 6'(i + 1), 6'(i), 1'b0);
            #1;
            if (alloc_tag_o !== 6'((6 + i) % 64) || alloc_ready_o !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL fill%0d got tag %0d rdy %b want %0d/1", i, alloc_tag_o, alloc_ready_o, (6 + i) % 64);
            end
            if (i == 58 && alloc_tag_o == 6'd0) wrapSeen = 1;
            tick();
        end
        testsRun++;
        testsRun++; if (wrapSeen != 1) begin testsFailed++; $display("[TB] FAIL wrap got %0d want 1", wrapSeen); end
        testsRun++; if ({alloc_ready_o, empty_o, alloc_tag_o} !== {1'b0, 1'b0, 6'd6}) begin testsFailed++; $display("[TB] FAIL full got %b/%b/%0d want 0/0/6", alloc_ready_o, empty_o, alloc_tag_o); end
        applyStimulus(1'b1, 6'd60, 6'd61, 1'b0);
        complete(6'd6, 1'b0);
        tick();
        cmpl_valid_i = 1'b0;
        #1;
        testsRun++; if ({commit_free_valid_o, commit_free_preg_o, alloc_ready_o} !== {1'b1, 6'd1, 1'b0}) begin testsFailed++; $display("[TB] FAIL full_commit got %b/%0d/%b want 1/1/0", commit_free_valid_o, commit_free_preg_o, alloc_ready_o); end
        tick();
        testsRun++; if ({alloc_ready_o, alloc_tag_o, head_tag_o} !== {1'b1, 6'd6, 6'd7}) begin testsFailed++; $display("[TB] FAIL ready_back got %b/%0d/%0d want 1/6/7", alloc_ready_o, alloc_tag_o, head_tag_o); end
        tick();
        idle();
        #1;
        testsRun++; if ({alloc_ready_o, alloc_tag_o} !== {1'b0, 6'd7}) begin testsFailed++; $display("[TB] FAIL refull got %b/%0d want 0/7", alloc_ready_o, alloc_tag_o); end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 6'd2, 6'd3, 1'b1);
        tick();
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1'b1, 6'(i), 6'(i + 30), 1'b0);
            tick();
        end
        idle();
        complete(6'd0, 1'b1);
        tick();
        idle();
        testsRun++; if (recover_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL pend_rec got %b want 1", recover_o); end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++; if ({recover_o, commit_free_valid_o, commit_free_preg_o} !== {1'b0, 1'b0, 6'd0}) begin testsFailed++; $display("[TB] FAIL rst_outs got %b/%b/%0d want 0/0/0", recover_o, commit_free_valid_o, commit_free_preg_o); end
        testsRun++; if ({alloc_ready_o, empty_o, alloc_tag_o, head_tag_o} !== {1'b1, 1'b1, 6'd0, 6'd0}) begin testsFailed++; $display("[TB] FAIL rst_state got %b/%b/%0d/%0d want 1/1/0/0", alloc_ready_o, empty_o, alloc_tag_o, head_tag_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        testsRun++; if ({recover_o, commit_free_valid_o, empty_o} !== 3'b001) begin testsFailed++; $display("[TB] FAIL post_rst got %b want 001", {recover_o, commit_free_valid_o, empty_o}); end
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_x0_dest();
        test_mispredict();
        test_invalid_cmpl();
        test_full_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer sitting directly downstream of the rename stage.
- Accepts renamed instructions in program order (dest old/new PREG, branch flag) and records out-of-order completions from execute.
- Retires one instruction per cycle from the head and returns the old dest PREG to the rename free list.
- When a mispredicted branch retires, it raises the recovery pulse that rename and dispatch consume.

Parameters:
N_ENTRIES, 64, ROB depth; power of two, >= 4
N_PHYS, 64, physical register count
TAG_W, $clog2(N_ENTRIES), ROB tag/index width (6 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid_i  in  1  rename output valid
alloc_ready_o  out  1  ROB can accept this cycle
alloc_rd_alloc_i  in  1  instruction allocated a new dest PREG (rd used, rd != x0)
alloc_rd_old_p_i  in  $clog2(N_PHYS)  previous mapping of rd
alloc_rd_new_p_i  in  $clog2(N_PHYS)  newly allocated PREG
alloc_is_branch_i  in  1  branch/jump
alloc_tag_o  out  TAG_W  index assigned to the accepted instruction (= tail)
cmpl_valid_i  in  1  execute completion strobe
cmpl_tag_i  in  TAG_W  completing entry
cmpl_mispredict_i  in  1  branch resolved mispredicted
commit_free_valid_o  out  1  old PREG is freed this cycle
commit_free_preg_o  out  $clog2(N_PHYS)  PREG being freed
recover_o  out  1  flush pulse (one cycle)
head_tag_o  out  TAG_W  oldest entry index
empty_o  out  1  no valid entries

Behaviour:
- State per entry: valid, done, mispredict, rd_alloc, rd_old_p, rd_new_p, is_branch. Pointers head/tail are TAG_W bits and wrap modulo N_ENTRIES. count is TAG_W+1 bits.
- Reset (async, rst_n low):
  - head = tail = 0, count = 0, all valid/done cleared.
  - Outputs: alloc_ready_o = 1, alloc_tag_o = 0, commit_free_valid_o = 0, commit_free_preg_o = 0, recover_o = 0, head_tag_o = 0, empty_o = 1.
  - Reset mid-operation discards all entries and emits no free or recover.
- Allocation:
  - alloc_ready_o = (count != N_ENTRIES) && !recover_o.
  - On valid && ready: write the entry at tail with done = 0; tail += 1.
  - alloc_tag_o = tail, combinational.
  - Full blocks allocation even if a commit occurs in the same cycle; no bypass.
- Completion:
  - On cmpl_valid_i, if entry[cmpl_tag_i].valid: set done = 1 and mispredict = cmpl_mispredict_i && is_branch.
  - Completion to an invalid entry is ignored.
  - A completion to the head is visible for commit on the next cycle.
- Commit (combinational from registered state): commit = entry[head].valid && entry[head].done.
  - commit_free_valid_o = commit && rd_alloc.
  - commit_free_preg_o = rd_old_p (0 when not freeing).
  - On commit: clear valid, head += 1, count -= 1.
- Simultaneous alloc and commit: count unchanged, both pointers advance.
- Recovery:
  - recover_o = commit && entry[head].mispredict. The branch itself retires normally (frees its old PREG if rd_alloc).
  - At the next edge: every entry's valid is cleared, head = tail = head+1, count = 0.
  - Allocation is blocked during the recover_o cycle.
  - Completions arriving in the recover_o cycle are dropped.
  - Squashed entries' rd_new_p are NOT freed; rename reclaims them by restoring its free-list checkpoint.
- empty_o = (count == 0). head_tag_o = head.
- Latency: alloc to earliest commit is 2 cycles (alloc, completion, commit).

Optional Feature:
ROB_PERF_EN
- Defined: adds outputs perf_commit_cnt_o[31:0] and perf_flush_cnt_o[31:0]. They count commits and recover_o pulses, wrap at 2^32, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rob_pkg holds:
  - localparams PREG_W and TAG_W defaults;
  - typedef rob_entry_t, a struct of valid, done, mispredict, rd_alloc, is_branch, rd_old_p, rd_new_p;
  - typedef rob_tag_t.
- Single flat module. Entry storage is a packed array of rob_entry_t; no sub-module is warranted.

Test Plan:
- Reset, then alloc 3 entries (rd_alloc = 1, old_p 5/6/7) and complete tags 2,0,1 in that order -> commits in order 0,1,2 on consecutive cycles freeing 5,6,7; empty_o = 1 afterwards.
- Fill 64 entries with no completions -> alloc_ready_o = 0 at count 64. Complete head and commit -> ready returns the following cycle; alloc_tag_o wraps 63 -> 0.
- Alloc with rd_alloc = 0 (x0 dest), then complete -> commit advances head with commit_free_valid_o = 0.
- Branch at tag 4 with 3 younger entries, complete 4 with mispredict = 1 -> when tag 4 is at head, recover_o = 1 for exactly one cycle; next cycle head = tail = 5, empty_o = 1; alloc is blocked during the pulse.
- Completion to an invalid tag 10 while empty -> no state change. Completion and commit of the same head in one cycle -> commit deferred one cycle.
- Assert rst_n low while 20 entries are live and recover is pending -> all outputs return to reset values immediately and no free or recover is emitted.
